// File: rtl/pa_lsu_pkg.sv
// Shared LSU definitions: protection width, byte-lane geometry helpers.
// Used by the write-buffer queue and its entries.
package pa_lsu_pkg;

    localparam int WB_PROT_W = 4;
    localparam int WB_BYTE_W = 8;

    function automatic int wb_bw(input int dataw);
        return dataw / WB_BYTE_W;
    endfunction

    function automatic int wb_ofs(input int dataw);
        return $clog2(dataw / WB_BYTE_W);
    endfunction

endpackage

// File: rtl/gated_clk_cell.sv
// Latch-based clock gate; enable is captured while the clock is low.
// Scan enable forces the clock through.
module gated_clk_cell (
    input  logic clk_in,
    input  logic local_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic en_lat;

    always_latch begin
        if (!clk_in) begin
            en_lat = local_en | pad_yy_icg_scan_en;
        end
    end

    assign clk_out = clk_in & en_lat;

endmodule

// File: rtl/pa_lsu_wb_queue_entry.sv
// One write-buffer slot: storage, same-word merge, late-data forwarding,
// and load overlap compare.
module pa_lsu_wb_queue_entry
    import pa_lsu_pkg::*;
#(
    parameter  int DATAW = 32,
    parameter  int ADDRW = 32,
    parameter  int PREGW = 6,
    localparam int BW    = wb_bw(DATAW),
    localparam int AW    = ADDRW - wb_ofs(DATAW)
) (
    input  logic                 clk,
    input  logic                 cpurst_b,
    input  logic                 flush,
    input  logic                 create_en,
    input  logic                 merge_en,
    input  logic [AW-1:0]        create_waddr,
    input  logic [BW-1:0]        create_be,
    input  logic [DATAW-1:0]     create_data,
    input  logic                 create_so,
    input  logic [WB_PROT_W-1:0] create_prot,
    input  logic                 create_depd,
    input  logic [PREGW-1:0]     create_preg,
    input  logic                 fwd_vld,
    input  logic [PREGW-1:0]     fwd_preg,
    input  logic [DATAW-1:0]     fwd_data,
    input  logic                 aissue,
    input  logic                 dfree,
    input  logic [AW-1:0]        ld_waddr,
    input  logic [BW-1:0]        ld_be,
    output logic                 vld,
    output logic                 aissued,
    output logic                 depd,
    output logic                 merge_hit,
    output logic                 ld_hit,
    output logic [AW-1:0]        waddr,
    output logic [BW-1:0]        be,
    output logic [DATAW-1:0]     data,
    output logic [WB_PROT_W-1:0] prot
);

    logic             so;
    logic [PREGW-1:0] preg;
    logic             fwd_hit;
    logic             crt_fwd;
    logic             data_en;
    logic             data_clk;
    logic [DATAW-1:0] merge_data;

    assign fwd_hit = fwd_vld & vld & depd & (preg == fwd_preg);
    assign crt_fwd = create_depd & fwd_vld & (create_preg == fwd_preg);
    assign data_en = create_en | merge_en | fwd_hit;

    always_comb begin
        merge_data = data;
        for (int i = 0; i < BW; i++) begin
            if (create_be[i]) begin
                merge_data[i*WB_BYTE_W +: WB_BYTE_W] =
                    create_data[i*WB_BYTE_W +: WB_BYTE_W];
            end
        end
    end

    gated_clk_cell u_data_gclk (
        .clk_in             (clk),
        .local_en           (data_en),
        .pad_yy_icg_scan_en (1'b0),
        .clk_out            (data_clk)
    );

    always_ff @(posedge data_clk) begin
        if (create_en) begin
            waddr <= create_waddr;
            be    <= create_be;
            so    <= create_so;
            prot  <= create_prot;
            preg  <= create_preg;
            data  <= crt_fwd ? fwd_data : create_data;
        end else if (merge_en) begin
            be    <= be | create_be;
            data  <= merge_data;
        end else if (fwd_hit) begin
            data  <= fwd_data;
        end
    end

    // Control bits stay on the free-running clock so flush always lands.
    always_ff @(posedge clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            vld     <= 1'b0;
            aissued <= 1'b0;
            depd    <= 1'b0;
        end else if (flush) begin
            vld     <= 1'b0;
            aissued <= 1'b0;
            depd    <= 1'b0;
        end else if (create_en) begin
            vld     <= 1'b1;
            aissued <= 1'b0;
            depd    <= create_depd & ~crt_fwd;
        end else begin
            if (dfree) begin
                vld     <= 1'b0;
                aissued <= 1'b0;
            end else if (aissue) begin
                aissued <= 1'b1;
            end
            if (fwd_hit) begin
                depd <= 1'b0;
            end
        end
    end

    assign merge_hit = vld & ~aissued & ~so & ~depd
                     & (waddr == create_waddr);
    assign ld_hit    = vld & (waddr == ld_waddr) & (|(be & ld_be));

endmodule

// File: rtl/pa_lsu_wb_queue.sv
// LSU store write buffer: in-order queue with merge, forwarding and
// split address/data bus drain.
module pa_lsu_wb_queue
    import pa_lsu_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int DATAW = 32,
    parameter  int ADDRW = 32,
    parameter  int PREGW = 6,
    localparam int BW    = wb_bw(DATAW),
    localparam int OFS   = wb_ofs(DATAW)
) (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst_b,
    input  logic                 rtu_yy_xx_async_flush,
    input  logic                 wb_create_vld,
    output logic                 wb_create_rdy,
    input  logic [ADDRW-1:0]     wb_create_addr,
    input  logic [BW-1:0]        wb_create_be,
    input  logic [DATAW-1:0]     wb_create_data,
    input  logic                 wb_create_so,
    input  logic [WB_PROT_W-1:0] wb_create_prot,
    input  logic                 wb_create_src1_depd,
    input  logic [PREGW-1:0]     wb_create_src1_preg,
    input  logic                 da_xx_fwd_vld,
    input  logic [PREGW-1:0]     da_xx_fwd_preg,
    input  logic [DATAW-1:0]     da_xx_fwd_data,
    input  logic                 ld_chk_vld,
    input  logic [ADDRW-1:0]     ld_chk_addr,
    input  logic [BW-1:0]        ld_chk_be,
    output logic                 ld_hit_wb,
    output logic                 wb_bus_addr_req,
    output logic [ADDRW-1:0]     wb_bus_addr,
    output logic [WB_PROT_W-1:0] wb_bus_prot,
    input  logic                 wb_bus_addr_ack,
    output logic [DATAW-1:0]     wb_bus_wdata,
    output logic [BW-1:0]        wb_bus_wstrb,
    input  logic                 wb_bus_data_ack,
    output logic                 wb_empty,
    output logic [DEPTH-1:0]     wb_dbginfo
);

    localparam int AW   = ADDRW - OFS;
    localparam int PTRW = $clog2(DEPTH);

    logic [PTRW-1:0] crt_ptr;
    logic [PTRW-1:0] aptr;
    logic [PTRW-1:0] dptr;
    logic [PTRW-1:0] yng_ptr;

    logic [DEPTH-1:0] e_vld;
    logic [DEPTH-1:0] e_aissued;
    logic [DEPTH-1:0] e_depd;
    logic [DEPTH-1:0] e_merge_hit;
    logic [DEPTH-1:0] e_ld_hit;
    logic [DEPTH-1:0] e_create;
    logic [DEPTH-1:0] e_merge;
    logic [DEPTH-1:0] e_aissue;
    logic [DEPTH-1:0] e_dfree;

    logic [AW-1:0]        e_waddr [DEPTH];
    logic [BW-1:0]        e_be    [DEPTH];
    logic [DATAW-1:0]     e_data  [DEPTH];
    logic [WB_PROT_W-1:0] e_prot  [DEPTH];

    logic          flush;
    logic          full;
    logic          merge_ok;
    logic          create_fire;
    logic          alloc;
    logic          merge;
    logic          addr_fire;
    logic          data_vld;
    logic          data_fire;
    logic [AW-1:0] create_waddr;
    logic [AW-1:0] ld_waddr;
    logic          unused_addr_lsb;

    assign flush        = rtu_yy_xx_async_flush;
    assign create_waddr = wb_create_addr[ADDRW-1:OFS];
    assign ld_waddr     = ld_chk_addr[ADDRW-1:OFS];
    assign unused_addr_lsb = ^{wb_create_addr[OFS-1:0], ld_chk_addr[OFS-1:0]};

    assign yng_ptr  = crt_ptr - PTRW'(1);
    assign merge_ok = e_merge_hit[yng_ptr] & ~wb_create_so
                    & ~wb_create_src1_depd;
    // Registered vld only: a slot freed this cycle is not reusable yet.
    assign full          = &e_vld;
    assign wb_create_rdy = ~full | merge_ok;

    assign create_fire = wb_create_vld & wb_create_rdy & ~flush;
    assign alloc       = create_fire & ~merge_ok;
    assign merge       = create_fire & merge_ok;

    assign wb_bus_addr_req = e_vld[aptr] & ~e_aissued[aptr] & ~e_depd[aptr];
    assign addr_fire       = wb_bus_addr_req & wb_bus_addr_ack & ~flush;
    assign data_vld        = e_vld[dptr] & e_aissued[dptr];
    assign data_fire       = data_vld & wb_bus_data_ack & ~flush;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign e_create[i] = alloc     & (crt_ptr == PTRW'(i));
        assign e_merge[i]  = merge     & (yng_ptr == PTRW'(i));
        assign e_aissue[i] = addr_fire & (aptr    == PTRW'(i));
        assign e_dfree[i]  = data_fire & (dptr    == PTRW'(i));

        pa_lsu_wb_queue_entry #(
            .DATAW (DATAW),
            .ADDRW (ADDRW),
            .PREGW (PREGW)
        ) u_entry (
            .clk          (forever_cpuclk),
            .cpurst_b     (cpurst_b),
            .flush        (flush),
            .create_en    (e_create[i]),
            .merge_en     (e_merge[i]),
            .create_waddr (create_waddr),
            .create_be    (wb_create_be),
            .create_data  (wb_create_data),
            .create_so    (wb_create_so),
            .create_prot  (wb_create_prot),
            .create_depd  (wb_create_src1_depd),
            .create_preg  (wb_create_src1_preg),
            .fwd_vld      (da_xx_fwd_vld),
            .fwd_preg     (da_xx_fwd_preg),
            .fwd_data     (da_xx_fwd_data),
            .aissue       (e_aissue[i]),
            .dfree        (e_dfree[i]),
            .ld_waddr     (ld_waddr),
            .ld_be        (ld_chk_be),
            .vld          (e_vld[i]),
            .aissued      (e_aissued[i]),
            .depd         (e_depd[i]),
            .merge_hit    (e_merge_hit[i]),
            .ld_hit       (e_ld_hit[i]),
            .waddr        (e_waddr[i]),
            .be           (e_be[i]),
            .data         (e_data[i]),
            .prot         (e_prot[i])
        );
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            crt_ptr <= '0;
            aptr    <= '0;
            dptr    <= '0;
        end else if (flush) begin
            crt_ptr <= '0;
            aptr    <= '0;
            dptr    <= '0;
        end else begin
            if (alloc) begin
                crt_ptr <= crt_ptr + PTRW'(1);
            end
            if (addr_fire) begin
                aptr <= aptr + PTRW'(1);
            end
            if (data_fire) begin
                dptr <= dptr + PTRW'(1);
            end
        end
    end

    assign wb_bus_addr  = {e_waddr[aptr], {OFS{1'b0}}};
    assign wb_bus_prot  = e_prot[aptr];
    assign wb_bus_wdata = data_vld ? e_data[dptr] : '0;
    assign wb_bus_wstrb = data_vld ? e_be[dptr] : '0;

    assign ld_hit_wb  = ld_chk_vld & (|e_ld_hit);
    assign wb_empty   = ~(|e_vld);
    assign wb_dbginfo = e_vld;

endmodule

// File: tb/tb_pa_lsu_wb_queue.sv
// Directed bench for the LSU write buffer queue.
// Expected values are hand-computed constants.
module tb_pa_lsu_wb_queue;

    localparam int DEPTH = 4;
    localparam int DATAW = 32;
    localparam int ADDRW = 32;
    localparam int PREGW = 6;
    localparam int BW    = 4;

    logic             clk = 1'b0;
    logic             rst_b = 1'b0;
    logic             flush = 1'b0;
    logic             create_vld = 1'b0;
    logic             create_rdy;
    logic [ADDRW-1:0] create_addr = '0;
    logic [BW-1:0]    create_be = '0;
    logic [DATAW-1:0] create_data = '0;
    logic             create_so = 1'b0;
    logic [3:0]       create_prot = 4'h1;
    logic             create_depd = 1'b0;
    logic [PREGW-1:0] create_preg = '0;
    logic             fwd_vld = 1'b0;
    logic [PREGW-1:0] fwd_preg = '0;
    logic [DATAW-1:0] fwd_data = '0;
    logic             ld_vld = 1'b0;
    logic [ADDRW-1:0] ld_addr = '0;
    logic [BW-1:0]    ld_be = '0;
    logic             ld_hit;
    logic             areq;
    logic [ADDRW-1:0] baddr;
    logic [3:0]       bprot;
    logic             aack = 1'b0;
    logic [DATAW-1:0] wdata;
    logic [BW-1:0]    wstrb;
    logic             dack = 1'b0;
    logic             empty;
    logic [DEPTH-1:0] dbg;

    int checks = 0;
    int errors = 0;

    pa_lsu_wb_queue #(
        .DEPTH (DEPTH),
        .DATAW (DATAW),
        .ADDRW (ADDRW),
        .PREGW (PREGW)
    ) dut (
        .forever_cpuclk        (clk),
        .cpurst_b              (rst_b),
        .rtu_yy_xx_async_flush (flush),
        .wb_create_vld         (create_vld),
        .wb_create_rdy         (create_rdy),
        .wb_create_addr        (create_addr),
        .wb_create_be          (create_be),
        .wb_create_data        (create_data),
        .wb_create_so          (create_so),
        .wb_create_prot        (create_prot),
        .wb_create_src1_depd   (create_depd),
        .wb_create_src1_preg   (create_preg),
        .da_xx_fwd_vld         (fwd_vld),
        .da_xx_fwd_preg        (fwd_preg),
        .da_xx_fwd_data        (fwd_data),
        .ld_chk_vld            (ld_vld),
        .ld_chk_addr           (ld_addr),
        .ld_chk_be             (ld_be),
        .ld_hit_wb             (ld_hit),
        .wb_bus_addr_req       (areq),
        .wb_bus_addr           (baddr),
        .wb_bus_prot           (bprot),
        .wb_bus_addr_ack       (aack),
        .wb_bus_wdata          (wdata),
        .wb_bus_wstrb          (wstrb),
        .wb_bus_data_ack       (dack),
        .wb_empty              (empty),
        .wb_dbginfo            (dbg)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] d, input logic so);
        create_addr = a;
        create_be   = be;
        create_data = d;
        create_so   = so;
        create_depd = 1'b0;
        create_vld  = 1'b1;
        #1;
        chk("push_rdy", create_rdy, 1'b1);
        tick();
        create_vld  = 1'b0;
        create_so   = 1'b0;
    endtask

    task automatic drain(input logic [31:0] ea, input logic [31:0] ed,
                         input logic [3:0] es);
        int n = 0;
        while (!areq && n < 20) begin
            tick();
            n++;
        end
        chk("areq_wait", areq, 1'b1);
        chk("baddr", baddr, ea);
        aack = 1'b1;
        tick();
        aack = 1'b0;
        #1;
        chk("wstrb", wstrb, es);
        chk("wdata", wdata, ed);
        dack = 1'b1;
        tick();
        dack = 1'b0;
        #1;
    endtask

    initial begin
        logic [3:0] m;
        #1;
        chk("rst_empty", empty, 1'b1);
        chk("rst_areq", areq, 1'b0);
        chk("rst_dbg", dbg, 4'h0);
        #12 rst_b = 1'b1;
        tick();
        chk("rst_rdy", create_rdy, 1'b1);

        // fill, full/merge ready, coincident acks
        create_prot = 4'hB;
        for (int k = 0; k < 4; k++) begin
            push(32'h100 + 32'(4 * k), 4'hF, 32'hA000_0000 + 32'(k), 1'b0);
        end
        create_prot = 4'h1;
        #1;
        chk("full_dbg", dbg, 4'hF);
        chk("full_empty", empty, 1'b0);
        chk("full_areq", areq, 1'b1);
        chk("full_addr", baddr, 32'h100);
        chk("full_prot", bprot, 4'hB);
        chk("idle_wstrb", wstrb, 4'h0);
        create_vld  = 1'b1;
        create_addr = 32'h110;
        create_be   = 4'hF;
        #1;
        chk("rdy_full", create_rdy, 1'b0);
        create_addr = 32'h10E;
        create_be   = 4'h4;
        #1;
        chk("rdy_merge", create_rdy, 1'b1);
        create_vld  = 1'b0;
        aack = 1'b1;
        tick();
        aack = 1'b0;
        #1;
        chk("a1_addr", baddr, 32'h104);
        chk("d0_data", wdata, 32'hA000_0000);
        chk("d0_strb", wstrb, 4'hF);
        create_addr = 32'h110;
        aack = 1'b1;
        dack = 1'b1;
        #1;
        chk("rdy_ack_full", create_rdy, 1'b0);
        for (int k = 1; k < 4; k++) begin
            tick();
            aack = (k < 3);
            m = 4'hF << k;
            #1;
            chk("drain_dbg", dbg, m);
            chk("drain_data", wdata, 32'hA000_0000 + 32'(k));
            chk("drain_areq", areq, k < 3);
        end
        aack = 1'b0;
        tick();
        dack = 1'b0;
        #1;
        chk("drained_empty", empty, 1'b1);
        chk("drained_dbg", dbg, 4'h0);

        // merge and load overlap
        push(32'h200, 4'h3, 32'h0000_BBAA, 1'b0);
        ld_vld  = 1'b1;
        ld_addr = 32'h201;
        ld_be   = 4'h2;
        #1;
        chk("ld_hit_b2", ld_hit, 1'b1);
        ld_be = 4'h8;
        #1;
        chk("ld_miss_b8", ld_hit, 1'b0);
        ld_addr = 32'h205;
        ld_be   = 4'h2;
        #1;
        chk("ld_miss_word", ld_hit, 1'b0);
        ld_vld  = 1'b0;
        ld_addr = 32'h201;
        #1;
        chk("ld_novld", ld_hit, 1'b0);
        push(32'h202, 4'hC, 32'hDDCC_0000, 1'b0);
        #1;
        chk("merge_dbg", dbg, 4'h1);
        ld_vld = 1'b1;
        ld_be  = 4'h8;
        #1;
        chk("ld_hit_merged", ld_hit, 1'b1);
        chk("merge_addr", baddr, 32'h200);
        aack = 1'b1;
        tick();
        aack = 1'b0;
        #1;
        chk("ld_hit_aissued", ld_hit, 1'b1);
        chk("merge_strb", wstrb, 4'hF);
        chk("merge_data", wdata, 32'hDDCC_BBAA);
        ld_vld = 1'b0;
        dack = 1'b1;
        tick();
        dack = 1'b0;

        // late data via forwarding
        create_addr = 32'h400;
        create_be   = 4'hF;
        create_data = 32'hDEAD_BEEF;
        create_depd = 1'b1;
        create_preg = 6'd5;
        create_vld  = 1'b1;
        tick();
        create_vld  = 1'b0;
        create_depd = 1'b0;
        #1;
        chk("depd_areq0", areq, 1'b0);
        fwd_vld  = 1'b1;
        fwd_preg = 6'd6;
        fwd_data = 32'h0BAD_0BAD;
        tick();
        fwd_vld = 1'b0;
        #1;
        chk("depd_areq1", areq, 1'b0);
        fwd_vld  = 1'b1;
        fwd_preg = 6'd5;
        fwd_data = 32'h1234_5678;
        tick();
        fwd_vld = 1'b0;
        #1;
        chk("fwd_areq", areq, 1'b1);
        create_addr = 32'h500;
        create_data = 32'h5555_5555;
        create_depd = 1'b1;
        create_preg = 6'd9;
        create_vld  = 1'b1;
        fwd_vld     = 1'b1;
        fwd_preg    = 6'd9;
        fwd_data    = 32'hCAFE_F00D;
        tick();
        create_vld  = 1'b0;
        create_depd = 1'b0;
        fwd_vld     = 1'b0;
        drain(32'h400, 32'h1234_5678, 4'hF);
        drain(32'h500, 32'hCAFE_F00D, 4'hF);

        // strongly ordered never merges
        push(32'h300, 4'hF, 32'h0000_0033, 1'b1);
        push(32'h300, 4'hF, 32'h0000_0044, 1'b0);
        push(32'h310, 4'hF, 32'h0000_0055, 1'b0);
        #1;
        chk("so_dbg", dbg, 4'hB);
        drain(32'h300, 32'h0000_0033, 4'hF);
        drain(32'h300, 32'h0000_0044, 4'hF);
        drain(32'h310, 32'h0000_0055, 4'hF);

        // flush with one entry address-issued, acks pending
        push(32'h600, 4'hF, 32'h6666_0000, 1'b0);
        push(32'h604, 4'hF, 32'h6666_0004, 1'b0);
        push(32'h608, 4'hF, 32'h6666_0008, 1'b0);
        #1;
        chk("pre_flush_dbg", dbg, 4'hD);
        aack = 1'b1;
        tick();
        flush = 1'b1;
        dack  = 1'b1;
        tick();
        flush = 1'b0;
        aack  = 1'b0;
        dack  = 1'b0;
        #1;
        chk("flush_empty", empty, 1'b1);
        chk("flush_dbg", dbg, 4'h0);
        chk("flush_areq", areq, 1'b0);
        chk("flush_wstrb", wstrb, 4'h0);
        push(32'h700, 4'hF, 32'h0000_0077, 1'b0);
        #1;
        chk("post_flush_dbg", dbg, 4'h1);
        drain(32'h700, 32'h0000_0077, 4'hF);

        // pointer wrap over 2*DEPTH stores
        for (int i = 0; i < 2 * DEPTH; i++) begin
            push(32'h800 + 32'(4 * i), 4'hF, 32'hC000_0000 + 32'(i), 1'b0);
            m = 4'h1 << ((1 + i) % 4);
            #1;
            chk("wrap_dbg", dbg, m);
            drain(32'h800 + 32'(4 * i), 32'hC000_0000 + 32'(i), 4'hF);
        end
        chk("final_empty", empty, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
